// File: rtl/lsp_pre_select_pkg.sv
// Shared constants, state encoding and G.729 saturation helpers for the
// first-stage LSP codebook search.
//   NC0 / M        : codebook size and LSP order
//   LSPCB1         : default constant-memory base of lspcb1
//   MAX_32/MIN_32  : 32-bit saturation bounds
//   ST_*           : search FSM state encoding
//   sat16 / sat32  : wrap-free saturation of one-bit-wider results
package lsp_pre_select_pkg;

   localparam int unsigned NC0        = 128;
   localparam int unsigned M          = 10;

   localparam int unsigned ADDR_W     = 12;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned Q_W        = 16;
   localparam int unsigned ACC_W      = 32;
   localparam int unsigned CB_IDX_W   = 7;
   localparam int unsigned WORD_IDX_W = 4;
   localparam int unsigned PHASE_W    = 2;
   localparam int unsigned BASE_HI_W  = ADDR_W - WORD_IDX_W;

   localparam logic [ADDR_W-1:0]     LSPCB1    = 12'h000;
   localparam logic signed [ACC_W-1:0] MAX_32  = 32'sh7FFF_FFFF;
   localparam logic signed [ACC_W-1:0] MIN_32  = 32'sh8000_0000;
   localparam logic signed [Q_W-1:0]   MAX_16  = 16'sh7FFF;
   localparam logic signed [Q_W-1:0]   MIN_16  = 16'sh8000;

   localparam logic [WORD_IDX_W-1:0] WORD_LAST = WORD_IDX_W'(M - 1);
   localparam logic [CB_IDX_W-1:0]   CB_LAST   = CB_IDX_W'(NC0 - 1);
   localparam logic [PHASE_W-1:0]    PHASE_CAP = 2'd2;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD_RBUF = 3'd1;
   localparam logic [2:0] ST_CB_ADDR   = 3'd2;
   localparam logic [2:0] ST_CB_WAIT   = 3'd3;
   localparam logic [2:0] ST_CB_MAC    = 3'd4;
   localparam logic [2:0] ST_COMPARE   = 3'd5;
   localparam logic [2:0] ST_DONE      = 3'd6;

   // Overflow shows up as the two top bits disagreeing; clamp toward the sign.
   function automatic logic signed [Q_W-1:0] sat16(input logic [Q_W:0] x);
      if (x[Q_W] != x[Q_W-1]) return x[Q_W] ? MIN_16 : MAX_16;
      return x[Q_W-1:0];
   endfunction

   function automatic logic signed [ACC_W-1:0] sat32(input logic [ACC_W:0] x);
      if (x[ACC_W] != x[ACC_W-1]) return x[ACC_W] ? MIN_32 : MAX_32;
      return x[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/lsp_dist_mac.sv
// One step of a saturated squared-distance accumulation:
//   acc_c = L_add(acc, L_mult(d, d)),  d = sub(rb_word, cb_word)
// Ports:
//   rb_word  : target vector word (Q13)
//   cb_word  : codebook word (Q13)
//   acc      : running distance
//   acc_c    : updated distance (combinational)
module lsp_dist_mac
   import lsp_pre_select_pkg::*;
(
   input  logic signed [Q_W-1:0]   rb_word,
   input  logic signed [Q_W-1:0]   cb_word,
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] acc_c
);

   logic signed [Q_W-1:0]   diff;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] lmult;

   // sub(): 17-bit difference then clamp
   always_comb begin
      diff = sat16({rb_word[Q_W-1], rb_word} - {cb_word[Q_W-1], cb_word});
   end

   // L_mult(): the only overflowing case is 0x8000 * 0x8000
   always_comb begin
      prod = diff * diff;
      if (diff == MIN_16) lmult = MAX_32;
      else                lmult = {prod[ACC_W-2:0], 1'b0};
   end

   // L_add(): 33-bit sum then clamp
   always_comb begin
      acc_c = sat32({acc[ACC_W-1], acc} + {lmult[ACC_W-1], lmult});
   end

endmodule

// File: rtl/lsp_pre_select.sv
// First-stage LSP codebook pre-selection: loads the 10-word residual rbuf
// from scratch memory, walks all 128 lspcb1 codewords in constant memory,
// and reports the index of the codeword with minimum saturated squared
// distance.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a search (accepted in IDLE or DONE)
//   done                : high while the result is available
//   rbufAddr            : scratch base of rbuf (low nibble replaced by j)
//   lspcb1Addr          : constant-memory base of lspcb1
//   readRequested       : scratch read address
//   readIn              : scratch read data, [15:0] used
//   constantMemRequest  : constant-memory read address
//   constantMemIn       : constant read data, [15:0] used
//   cand                : winning codeword index
module lsp_pre_select
   import lsp_pre_select_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                done,
   input  logic [ADDR_W-1:0]   rbufAddr,
   input  logic [ADDR_W-1:0]   lspcb1Addr,
   output logic [ADDR_W-1:0]   readRequested,
   input  logic [DATA_W-1:0]   readIn,
   output logic [ADDR_W-1:0]   constantMemRequest,
   input  logic [DATA_W-1:0]   constantMemIn,
   output logic [CB_IDX_W-1:0] cand
);

   logic [2:0]                state_q, state_d;
   logic [PHASE_W-1:0]        phase_q, phase_d;
   logic [WORD_IDX_W-1:0]     j_q, j_d;
   logic [CB_IDX_W-1:0]       i_q, i_d;
   logic signed [Q_W-1:0]     rb_q [0:M-1];
   logic signed [Q_W-1:0]     rb_d [0:M-1];
   logic [BASE_HI_W-1:0]      rbuf_base_q, rbuf_base_d;
   logic [ADDR_W-1:0]         cb_ptr_q, cb_ptr_d;
   logic signed [ACC_W-1:0]   l_tmp_q, l_tmp_d;
   logic signed [ACC_W-1:0]   l_dmin_q, l_dmin_d;
   logic [CB_IDX_W-1:0]       cand_d;
   logic                      done_d;
   logic [ADDR_W-1:0]         rd_addr_d;
   logic [ADDR_W-1:0]         cm_addr_d;
   logic signed [ACC_W-1:0]   mac_acc;
   logic                      launch;
   logic                      unused_bits_c;

   // Upper data halves and the rbuf base low nibble carry no information.
   assign unused_bits_c = ^{readIn[DATA_W-1:Q_W], constantMemIn[DATA_W-1:Q_W],
                            rbufAddr[WORD_IDX_W-1:0]};

   lsp_dist_mac u_mac (
      .rb_word (rb_q[j_q]),
      .cb_word (constantMemIn[Q_W-1:0]),
      .acc     (l_tmp_q),
      .acc_c   (mac_acc)
   );

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      j_d         = j_q;
      i_d         = i_q;
      rb_d        = rb_q;
      rbuf_base_d = rbuf_base_q;
      cb_ptr_d    = cb_ptr_q;
      l_tmp_d     = l_tmp_q;
      l_dmin_d    = l_dmin_q;
      cand_d      = cand;
      rd_addr_d   = readRequested;
      cm_addr_d   = constantMemRequest;
      launch      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            j_d      = '0;
            i_d      = '0;
            l_tmp_d  = '0;
            cand_d   = '0;
            l_dmin_d = MAX_32;
            launch   = start;
         end

         // phase 0 drives the address, phase 1 waits, phase 2 captures
         ST_LOAD_RBUF: begin
            if (phase_q == PHASE_CAP) begin
               rb_d[j_q] = readIn[Q_W-1:0];
               phase_d   = '0;
               if (j_q == WORD_LAST) begin
                  j_d       = '0;
                  cm_addr_d = cb_ptr_q;
                  state_d   = ST_CB_ADDR;
               end else begin
                  j_d       = j_q + 4'd1;
                  rd_addr_d = {rbuf_base_q, j_q + 4'd1};
               end
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end

         ST_CB_ADDR: state_d = ST_CB_WAIT;

         ST_CB_WAIT: state_d = ST_CB_MAC;

         ST_CB_MAC: begin
            l_tmp_d  = mac_acc;
            cb_ptr_d = cb_ptr_q + 12'd1;
            if (j_q == WORD_LAST) begin
               state_d = ST_COMPARE;
            end else begin
               j_d       = j_q + 4'd1;
               cm_addr_d = cb_ptr_q + 12'd1;
               state_d   = ST_CB_ADDR;
            end
         end

         // strict less-than keeps the lowest index on ties
         ST_COMPARE: begin
            if (l_tmp_q < l_dmin_q) begin
               l_dmin_d = l_tmp_q;
               cand_d   = i_q;
            end
            l_tmp_d = '0;
            j_d     = '0;
            if (i_q == CB_LAST) begin
               state_d = ST_DONE;
            end else begin
               i_d       = i_q + 7'd1;
               cm_addr_d = cb_ptr_q;
               state_d   = ST_CB_ADDR;
            end
         end

         ST_DONE: launch = start;

         default: state_d = ST_IDLE;
      endcase

      // Accepting start: fresh search state and base addresses captured here
      if (launch) begin
         j_d         = '0;
         i_d         = '0;
         phase_d     = '0;
         l_tmp_d     = '0;
         cand_d      = '0;
         l_dmin_d    = MAX_32;
         rbuf_base_d = rbufAddr[ADDR_W-1:WORD_IDX_W];
         cb_ptr_d    = lspcb1Addr;
         rd_addr_d   = {rbufAddr[ADDR_W-1:WORD_IDX_W], 4'd0};
         state_d     = ST_LOAD_RBUF;
      end

      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= ST_IDLE;
         phase_q            <= '0;
         j_q                <= '0;
         i_q                <= '0;
         rb_q               <= '{default: '0};
         rbuf_base_q        <= '0;
         cb_ptr_q           <= LSPCB1;
         l_tmp_q            <= '0;
         l_dmin_q           <= MAX_32;
         cand               <= '0;
         done               <= 1'b0;
         readRequested      <= '0;
         constantMemRequest <= '0;
      end else begin
         state_q            <= state_d;
         phase_q            <= phase_d;
         j_q                <= j_d;
         i_q                <= i_d;
         rb_q               <= rb_d;
         rbuf_base_q        <= rbuf_base_d;
         cb_ptr_q           <= cb_ptr_d;
         l_tmp_q            <= l_tmp_d;
         l_dmin_q           <= l_dmin_d;
         cand               <= cand_d;
         done               <= done_d;
         readRequested      <= rd_addr_d;
         constantMemRequest <= cm_addr_d;
      end
   end

endmodule

// File: tb/tb_lsp_pre_select.sv
// Self-checking bench for lsp_pre_select: two-cycle-latency memory models,
// directed corner frames and randomized frames against a plain-arithmetic
// nearest-codeword reference.
module tb_lsp_pre_select;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        done;
   logic [11:0] rbufAddr;
   logic [11:0] lspcb1Addr;
   logic [11:0] readRequested;
   logic [31:0] readIn;
   logic [11:0] constantMemRequest;
   logic [31:0] constantMemIn;
   logic [6:0]  cand;

   int n_cmp = 0;
   int n_err = 0;

   int          m_rb [10];
   int          m_cb [128][10];
   logic [31:0] scratch [0:4095];
   logic [31:0] cmem    [0:4095];
   logic [31:0] rd_pipe, cm_pipe;

   always #5 clk = ~clk;

   lsp_pre_select dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .done               (done),
      .rbufAddr           (rbufAddr),
      .lspcb1Addr         (lspcb1Addr),
      .readRequested      (readRequested),
      .readIn             (readIn),
      .constantMemRequest (constantMemRequest),
      .constantMemIn      (constantMemIn),
      .cand               (cand)
   );

   // Synchronous memories: address seen at edge N+1, data out after edge N+2
   always @(posedge clk) begin
      rd_pipe       <= scratch[readRequested];
      readIn        <= rd_pipe;
      cm_pipe       <= cmem[constantMemRequest];
      constantMemIn <= cm_pipe;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int rand_s16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   function automatic int sat16(input int x);
      if (x > 32767)  return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // Nearest codeword by saturated squared distance, lowest index on ties
   function automatic int model_cand();
      longint max32 = 64'd2147483647;
      longint dmin  = max32;
      int     best  = 0;
      for (int i = 0; i < 128; i++) begin
         longint acc = 0;
         for (int j = 0; j < 10; j++) begin
            int     d = sat16(m_rb[j] - m_cb[i][j]);
            longint p = 2 * longint'(d) * longint'(d);
            if (p > max32) p = max32;
            acc = acc + p;
            if (acc > max32) acc = max32;
         end
         if (acc < dmin) begin
            dmin = acc;
            best = i;
         end
      end
      return best;
   endfunction

   // Place the model vectors into memory with garbage everywhere else
   task automatic load_frame(input int rb_base, input int cb_base);
      logic [11:0] rb_a;
      rb_a = 12'(rb_base);
      for (int a = 0; a < 4096; a++) begin
         scratch[a] = $urandom;
         cmem[a]    = $urandom;
      end
      for (int j = 0; j < 10; j++)
         scratch[{rb_a[11:4], 4'(j)}] = {16'($urandom), 16'(m_rb[j])};
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 10; j++)
            cmem[12'(cb_base + 10 * i + j)] = {16'($urandom), 16'(m_cb[i][j])};
      rbufAddr   = rb_a;
      lspcb1Addr = 12'(cb_base);
   endtask

   // Pulse start and count cycles until done; optional re-start while busy
   task automatic do_search(input int reassert_at, input bit scramble, output int lat);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (scramble) begin
         rbufAddr   = 12'($urandom);
         lspcb1Addr = 12'($urandom);
      end
      lat = 0;
      while (lat < 4500) begin
         @(posedge clk);
         lat++;
         #1;
         start = (lat == reassert_at);
         if (done) break;
      end
      start = 1'b0;
      check("done_seen", longint'(done), 1);
   endtask

   initial begin
      int lat;
      int exp;

      reset      = 1'b1;
      start      = 1'b0;
      rbufAddr   = '0;
      lspcb1Addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", longint'(done), 0);
      check("rst_cand", longint'(cand), 0);
      check("rst_rdaddr", longint'(readRequested), 0);
      check("rst_cmaddr", longint'(constantMemRequest), 0);
      @(negedge clk) reset = 1'b0;

      // Codeword 5 exact match, rest at 0x0100
      for (int j = 0; j < 10; j++) m_rb[j] = 0;
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 10; j++) m_cb[i][j] = (i == 5) ? 0 : 256;
      load_frame(int'($urandom_range(4095)), int'($urandom_range(4095)));
      do_search(0, 1'b1, lat);
      check("latency_a", lat, 3998);
      check("cand_a", longint'(cand), 5);
      @(posedge clk); #1;
      check("hold_done", longint'(done), 1);
      check("hold_cand", longint'(cand), 5);

      // All identical: tie keeps index 0 (started from DONE)
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 10; j++) m_cb[i][j] = 512;
      m_cb[0][0] = 512;
      load_frame(16, 100);
      do_search(0, 1'b0, lat);
      check("cand_tie", longint'(cand), 0);

      // Everything saturates: cand stays 0
      for (int j = 0; j < 10; j++) m_rb[j] = 32767;
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 10; j++) m_cb[i][j] = -32768;
      load_frame(48, 4090);
      do_search(0, 1'b0, lat);
      check("cand_sat", longint'(cand), 0);
      check("latency_sat", lat, 3998);

      // Reset mid-search with a winner already recorded
      for (int j = 0; j < 10; j++) m_rb[j] = 0;
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 10; j++) m_cb[i][j] = 1000 - 7 * i;
      load_frame(32, 7);
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      repeat (1499) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_done", longint'(done), 0);
      check("midrst_cand", longint'(cand), 0);
      check("midrst_rdaddr", longint'(readRequested), 0);
      check("midrst_cmaddr", longint'(constantMemRequest), 0);
      @(negedge clk) reset = 1'b0;
      repeat (5) @(posedge clk);
      #1 check("idle_done", longint'(done), 0);

      // Fresh search with the last codeword closest
      for (int j = 0; j < 10; j++) m_rb[j] = int'($urandom_range(2000)) - 1000;
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 10; j++) m_cb[i][j] = (i == 127) ? m_rb[j] : m_rb[j] + 300;
      load_frame(int'($urandom_range(4095)), int'($urandom_range(4095)));
      do_search(0, 1'b1, lat);
      check("cand_last", longint'(cand), 127);
      check("latency_last", lat, 3998);

      // start while busy is ignored
      for (int j = 0; j < 10; j++) m_rb[j] = int'($urandom_range(2000)) - 1000;
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 10; j++) m_cb[i][j] = int'($urandom_range(2000)) - 1000;
      load_frame(int'($urandom_range(4095)), int'($urandom_range(4095)));
      exp = model_cand();
      do_search(200, 1'b1, lat);
      check("latency_busy", lat, 3998);
      check("cand_busy", longint'(cand), exp);

      // Randomized back-to-back frames
      for (int f = 0; f < 6; f++) begin
         for (int j = 0; j < 10; j++)
            m_rb[j] = (f % 3 == 1) ? rand_s16() : int'($urandom_range(2000)) - 1000;
         for (int i = 0; i < 128; i++)
            for (int j = 0; j < 10; j++) begin
               case (f % 3)
                  0:       m_cb[i][j] = int'($urandom_range(2000)) - 1000;
                  1:       m_cb[i][j] = rand_s16();
                  default: m_cb[i][j] = m_rb[j] + int'($urandom_range(6)) - 3;
               endcase
            end
         load_frame(int'($urandom_range(4095)), (f == 2) ? 4000 : int'($urandom_range(4095)));
         exp = model_cand();
         do_search(0, 1'b1, lat);
         check($sformatf("cand_rand%0d", f), longint'(cand), exp);
         check($sformatf("latency_rand%0d", f), lat, 3998);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
